// File: rtl/dsi_hdr_sched.sv
// dsi_hdr_sched: arbitrates command/video header requests for the shared ECC
// generator, waits for the ECC byte and serializes the 4-byte DSI packet
// header (DI, WC LSB, WC MSB, ECC) over a valid/ready byte stream.
//
// Byte stream handshake: a byte transfers on every rising edge where
// byte_valid and byte_ready are both high; byte_data/byte_last stay stable
// while byte_valid is high and byte_ready is low; byte_valid never drops
// without a transfer except on reset.
module dsi_hdr_sched #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        dsi_clk,
  input  logic        dsi_rst,
  input  logic        cmd_req,
  input  logic [23:0] cmd_hdr,
  output logic        cmd_gnt,
  output logic        cmd_done,
  input  logic        vid_req,
  input  logic [23:0] vid_hdr,
  output logic        vid_gnt,
  output logic        vid_done,
  output logic [23:0] ecc_hdr,
  output logic        ecc_start,
  input  logic [7:0]  ecc_in,
  input  logic        ecc_done,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        byte_last,
  output logic        busy,
  output logic        ecc_timeout
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  localparam logic SRC_CMD = 1'b0;
  localparam logic SRC_VID = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_ECC, S_SEND, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [23:0]   hdr_q, hdr_d;
  logic [7:0]    ecc_q, ecc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;

  // Next-cycle values of every registered output
  logic       cmd_gnt_d, vid_gnt_d, cmd_done_d, vid_done_d;
  logic       ecc_start_d, byte_valid_d, byte_last_d, busy_d, ecc_timeout_d;
  logic [7:0] byte_data_d;
  logic       win;

  // State, datapath and output registers; outputs are computed from the
  // next-state values so every port is driven straight from a flop
  always_ff @(posedge dsi_clk) begin
    if (dsi_rst) begin
      state_q     <= S_IDLE;
      owner_q     <= SRC_CMD;
      last_q      <= SRC_VID;
      hdr_q       <= '0;
      ecc_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      cmd_gnt     <= 1'b0;
      vid_gnt     <= 1'b0;
      cmd_done    <= 1'b0;
      vid_done    <= 1'b0;
      ecc_start   <= 1'b0;
      byte_data   <= '0;
      byte_valid  <= 1'b0;
      byte_last   <= 1'b0;
      busy        <= 1'b0;
      ecc_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      hdr_q       <= hdr_d;
      ecc_q       <= ecc_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      cmd_gnt     <= cmd_gnt_d;
      vid_gnt     <= vid_gnt_d;
      cmd_done    <= cmd_done_d;
      vid_done    <= vid_done_d;
      ecc_start   <= ecc_start_d;
      byte_data   <= byte_data_d;
      byte_valid  <= byte_valid_d;
      byte_last   <= byte_last_d;
      busy        <= busy_d;
      ecc_timeout <= ecc_timeout_d;
    end
  end

  // Next-state logic: round-robin arbitration, ECC wait with timeout, byte index
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    hdr_d   = hdr_q;
    ecc_d   = ecc_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    // On a tie the source that did not win last time goes first
    if (cmd_req && vid_req) win = ~last_q;
    else                    win = vid_req;
    case (state_q)
      S_IDLE: begin
        if (cmd_req || vid_req) begin
          owner_d = win;
          last_d  = win;
          hdr_d   = (win == SRC_VID) ? vid_hdr : cmd_hdr;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT_ECC;
      end
      S_WAIT_ECC: begin
        // The timeout pulse is already out once the counter is full, so a
        // late ecc_done in that cycle no longer rescues the packet
        if (cnt_q == CNT_MAX) begin
          hdr_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (ecc_done) begin
          ecc_d   = ecc_in;
          idx_d   = 2'd0;
          state_d = S_SEND;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SEND: begin
        if (byte_ready) begin
          if (idx_q == 2'd3) state_d = S_DONE;
          else               idx_d   = idx_q + 2'd1;
        end
      end
      S_DONE: begin
        hdr_d   = '0;
        idx_d   = 2'd0;
        state_d = S_IDLE;
      end
      default: begin
        hdr_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode from the next-state values, registered above
  always_comb begin
    cmd_gnt_d     = (state_d == S_START) && (owner_d == SRC_CMD);
    vid_gnt_d     = (state_d == S_START) && (owner_d == SRC_VID);
    cmd_done_d    = (state_d == S_DONE)  && (owner_d == SRC_CMD);
    vid_done_d    = (state_d == S_DONE)  && (owner_d == SRC_VID);
    ecc_start_d   = (state_d == S_START);
    byte_valid_d  = (state_d == S_SEND);
    byte_last_d   = (state_d == S_SEND) && (idx_d == 2'd3);
    busy_d        = (state_d != S_IDLE);
    ecc_timeout_d = (state_d == S_WAIT_ECC) && (cnt_d == CNT_MAX);
    byte_data_d   = 8'h00;
    if (state_d == S_SEND) begin
      case (idx_d)
        2'd0:    byte_data_d = hdr_d[7:0];
        2'd1:    byte_data_d = hdr_d[15:8];
        2'd2:    byte_data_d = hdr_d[23:16];
        default: byte_data_d = ecc_d;
      endcase
    end
  end

  assign ecc_hdr = hdr_q;

endmodule

// File: tb/tb_dsi_hdr_sched.sv
// Directed bench for dsi_hdr_sched: reset, single packet, round-robin ties,
// backpressure, ECC timeout, mid-packet reset and stray ecc_done pulses.
module tb_dsi_hdr_sched;

  logic        dsi_clk = 1'b0;
  logic        dsi_rst;
  logic        cmd_req, vid_req;
  logic [23:0] cmd_hdr, vid_hdr;
  logic        cmd_gnt, cmd_done, vid_gnt, vid_done;
  logic [23:0] ecc_hdr;
  logic        ecc_start, ecc_done;
  logic [7:0]  ecc_in, byte_data;
  logic        byte_valid, byte_ready, byte_last, busy, ecc_timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  dsi_hdr_sched #(.TIMEOUT_CYCLES(16)) dut (
    .dsi_clk(dsi_clk), .dsi_rst(dsi_rst),
    .cmd_req(cmd_req), .cmd_hdr(cmd_hdr), .cmd_gnt(cmd_gnt), .cmd_done(cmd_done),
    .vid_req(vid_req), .vid_hdr(vid_hdr), .vid_gnt(vid_gnt), .vid_done(vid_done),
    .ecc_hdr(ecc_hdr), .ecc_start(ecc_start), .ecc_in(ecc_in), .ecc_done(ecc_done),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_last(byte_last), .busy(busy), .ecc_timeout(ecc_timeout)
  );

  // Clock
  always #5 dsi_clk = ~dsi_clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge dsi_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".cmd_gnt"},     32'(cmd_gnt),     0);
    chk({tag, ".vid_gnt"},     32'(vid_gnt),     0);
    chk({tag, ".cmd_done"},    32'(cmd_done),    0);
    chk({tag, ".vid_done"},    32'(vid_done),    0);
    chk({tag, ".ecc_hdr"},     32'(ecc_hdr),     0);
    chk({tag, ".ecc_start"},   32'(ecc_start),   0);
    chk({tag, ".byte_data"},   32'(byte_data),   0);
    chk({tag, ".byte_valid"},  32'(byte_valid),  0);
    chk({tag, ".byte_last"},   32'(byte_last),   0);
    chk({tag, ".busy"},        32'(busy),        0);
    chk({tag, ".ecc_timeout"}, 32'(ecc_timeout), 0);
  endtask

  // Called in the START cycle: checks grant, header and the start pulse
  task automatic chk_grant(input string tag, input logic is_vid, input logic [23:0] hdr);
    chk({tag, ".cmd_gnt"},   32'(cmd_gnt),   32'(!is_vid));
    chk({tag, ".vid_gnt"},   32'(vid_gnt),   32'(is_vid));
    chk({tag, ".ecc_start"}, 32'(ecc_start), 1);
    chk({tag, ".ecc_hdr"},   32'(ecc_hdr),   32'(hdr));
    chk({tag, ".busy"},      32'(busy),      1);
  endtask

  // Called in a WAIT_ECC cycle with byte_ready high: pulses ecc_done, checks
  // the four bytes, the done pulse and the return to IDLE
  task automatic finish_packet(input string tag, input logic is_vid,
                               input logic [23:0] hdr, input logic [7:0] ecc);
    logic [7:0] exp_b [4];
    exp_b[0] = hdr[7:0];
    exp_b[1] = hdr[15:8];
    exp_b[2] = hdr[23:16];
    exp_b[3] = ecc;
    ecc_done = 1'b1;
    ecc_in   = ecc;
    step();
    ecc_done = 1'b0;
    ecc_in   = 8'h00;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.valid%0d", tag, i), 32'(byte_valid), 1);
      chk($sformatf("%s.data%0d", tag, i),  32'(byte_data),  32'(exp_b[i]));
      chk($sformatf("%s.last%0d", tag, i),  32'(byte_last),  32'(i == 3));
      step();
    end
    chk({tag, ".cmd_done"},   32'(cmd_done),   32'(!is_vid));
    chk({tag, ".vid_done"},   32'(vid_done),   32'(is_vid));
    chk({tag, ".done_valid"}, 32'(byte_valid), 0);
    step();
    chk({tag, ".idle_busy"},  32'(busy),       0);
    chk({tag, ".idle_done"},  32'(cmd_done | vid_done), 0);
  endtask

  initial begin
    dsi_rst = 1'b1;
    cmd_req = 1'b0; vid_req = 1'b0;
    cmd_hdr = '0;   vid_hdr = '0;
    ecc_done = 1'b0; ecc_in = '0;
    byte_ready = 1'b1;

    // 1: reset for 3 cycles, then one command packet
    repeat (3) step();
    chk_all_zero("reset");
    dsi_rst = 1'b0;
    step();
    cmd_req = 1'b1; cmd_hdr = 24'h000439;
    step();
    chk_grant("single.gnt", 1'b0, 24'h000439);
    cmd_req = 1'b0;
    step();
    chk("single.gnt_pulse",   32'(cmd_gnt),   0);
    chk("single.start_pulse", 32'(ecc_start), 0);
    step();
    finish_packet("single", 1'b0, 24'h000439, 8'hBA);

    // 2: tie with both requests held; grants alternate starting with cmd
    dsi_rst = 1'b1;
    repeat (3) step();
    dsi_rst = 1'b0;
    cmd_req = 1'b1; cmd_hdr = 24'h000105;
    vid_req = 1'b1; vid_hdr = 24'h07803E;
    for (int g = 0; g < 4; g++) begin
      step();
      chk_grant($sformatf("tie%0d", g), 1'(g % 2), (g % 2) ? 24'h07803E : 24'h000105);
      if (g == 3) begin
        cmd_req = 1'b0; vid_req = 1'b0;
      end
      step();
      finish_packet($sformatf("tie%0d", g), 1'(g % 2),
                    (g % 2) ? 24'h07803E : 24'h000105, 8'h40 + 8'(g));
    end

    // 3: backpressure for 3 cycles at idx1
    cmd_req = 1'b1; cmd_hdr = 24'h000439;
    step();
    chk_grant("bp.gnt", 1'b0, 24'h000439);
    cmd_req = 1'b0;
    step();
    ecc_done = 1'b1; ecc_in = 8'hBA;
    step();
    ecc_done = 1'b0;
    chk("bp.data0", 32'(byte_data), 32'h39);
    step();
    chk("bp.data1", 32'(byte_data), 32'h04);
    byte_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk($sformatf("bp.stall%0d_data", s),  32'(byte_data),  32'h04);
      chk($sformatf("bp.stall%0d_valid", s), 32'(byte_valid), 1);
      chk($sformatf("bp.stall%0d_done", s),  32'(cmd_done),   0);
    end
    byte_ready = 1'b1;
    step();
    chk("bp.data2", 32'(byte_data), 32'h00);
    step();
    chk("bp.data3", 32'(byte_data), 32'hBA);
    chk("bp.last3", 32'(byte_last), 1);
    step();
    chk("bp.done", 32'(cmd_done), 1);
    step();
    chk("bp.idle", 32'(busy), 0);

    // 4: ECC timeout, then a normal video packet
    cmd_req = 1'b1; cmd_hdr = 24'h123456;
    step();
    chk_grant("to.gnt", 1'b0, 24'h123456);
    cmd_req = 1'b0;
    step();
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("to.w%0d_timeout", k + 1), 32'(ecc_timeout), 32'(k == 16));
      chk($sformatf("to.w%0d_valid", k + 1),   32'(byte_valid),  0);
    end
    step();
    chk("to.after_timeout", 32'(ecc_timeout), 0);
    chk("to.after_busy",    32'(busy),        0);
    chk("to.after_done",    32'(cmd_done | vid_done), 0);
    vid_req = 1'b1; vid_hdr = 24'h0A0B0C;
    step();
    chk_grant("to.next_gnt", 1'b1, 24'h0A0B0C);
    vid_req = 1'b0;
    step();
    finish_packet("to.next", 1'b1, 24'h0A0B0C, 8'h77);

    // 5: reset during SEND at idx2, then a tie goes to cmd
    cmd_req = 1'b1; cmd_hdr = 24'h000439;
    step();
    cmd_req = 1'b0;
    step();
    ecc_done = 1'b1; ecc_in = 8'hBA;
    step();
    ecc_done = 1'b0;
    step();
    step();
    chk("mid.idx2_data", 32'(byte_data), 32'h00);
    dsi_rst = 1'b1;
    step();
    chk_all_zero("mid.reset");
    dsi_rst = 1'b0;
    cmd_req = 1'b1; cmd_hdr = 24'h000105;
    vid_req = 1'b1; vid_hdr = 24'h07803E;
    step();
    chk_grant("mid.tie", 1'b0, 24'h000105);
    cmd_req = 1'b0; vid_req = 1'b0;
    step();
    finish_packet("mid.pkt", 1'b0, 24'h000105, 8'h3C);

    // 6: stray ecc_done in IDLE and in the START cycle
    ecc_done = 1'b1; ecc_in = 8'hEE;
    step();
    ecc_done = 1'b0;
    chk("stray.idle_busy", 32'(busy), 0);
    cmd_req = 1'b1; cmd_hdr = 24'h002215;
    step();
    chk_grant("stray.gnt", 1'b0, 24'h002215);
    cmd_req = 1'b0;
    ecc_done = 1'b1; ecc_in = 8'hEE;
    step();
    ecc_done = 1'b0; ecc_in = 8'h00;
    chk("stray.wait1_valid", 32'(byte_valid), 0);
    step();
    chk("stray.wait2_valid", 32'(byte_valid), 0);
    finish_packet("stray.pkt", 1'b0, 24'h002215, 8'h5C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dsi_hdr_sched.md
# dsi_hdr_sched

- Arbitrates between the command and video packet sources for the single shared ECC generator and the header byte stream.
- Latches the winning 24-bit packet header and triggers the ECC generator, then waits for its result.
- Serializes the 4-byte DSI packet header (DI, WC LSB, WC MSB, ECC) toward the lane distributor using a valid/ready handshake.
- Sits between the DSI command/video front-ends and `ecc_gen` in the `dsi_clk` domain.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16, max cycles spent waiting for `ecc_done` after `ecc_start`; legal range ≥ 2.

Ports:
- dsi_clk  in  1  sole clock; all logic on rising edge.
- dsi_rst  in  1  reset, synchronous, active-high.
- cmd_req  in  1  command source requests a header slot; held until `cmd_gnt`.
- cmd_hdr  in  24  [7:0] DI, [23:8] WC; stable while `cmd_req`=1.
- cmd_gnt  out  1  one-cycle pulse: `cmd_hdr` captured.
- cmd_done  out  1  one-cycle pulse: command header fully sent.
- vid_req / vid_hdr / vid_gnt / vid_done: same as cmd_*, for the video source.
- ecc_hdr  out  24  latched header to ECC generator; held from START until return to IDLE.
- ecc_start  out  1  one-cycle pulse; drives `ecc_gen.fifo_done`.
- ecc_in  in  8  ECC byte from generator; valid in the cycle `ecc_done`=1.
- ecc_done  in  1  ECC-ready pulse from generator.
- byte_data  out  8  header byte.
- byte_valid  out  1  `byte_data` valid.
- byte_ready  in  1  downstream accepts the byte when `byte_valid`&`byte_ready`.
- byte_last  out  1  high with the ECC byte (index 3).
- busy  out  1  state ≠ IDLE.
- ecc_timeout  out  1  one-cycle pulse on timeout abort.

## Operation
- States: IDLE, START, WAIT_ECC, SEND, DONE.
- IDLE: if any request is present, arbitrate:
  - Round-robin with a single `last` pointer; the source that did not win last time takes priority on a tie.
  - Reset value of `last` = video, so the first tie goes to command.
  - A single requester always wins.
  - Latch the winner's header into `hdr_q`, record `owner`, set `last`=owner, go to START.
- START: `*_gnt`(owner)=1 and `ecc_start`=1 for this one cycle; clear the wait counter; go to WAIT_ECC.
- WAIT_ECC:
  - On `ecc_done`=1, capture `ecc_in` into `ecc_q`, set byte idx=0, go to SEND.
  - Otherwise increment the counter (width $clog2(TIMEOUT_CYCLES+1)).
  - When the counter reaches TIMEOUT_CYCLES with no `ecc_done`: pulse `ecc_timeout`, issue no `*_done`, drop the packet, go to IDLE.
- SEND:
  - `byte_valid`=1; `byte_data` = idx0 `hdr_q[7:0]`, idx1 `hdr_q[15:8]`, idx2 `hdr_q[23:16]`, idx3 `ecc_q`.
  - idx advances only on handshake; `byte_data` is held stable while stalled.
  - `byte_last`=1 when idx=3; handshake at idx=3 → DONE.
- DONE: `*_done`(owner)=1 for one cycle; go to IDLE.
- Simultaneous events and ignored inputs:
  - Requests arriving outside IDLE are not sampled; they wait until IDLE.
  - `ecc_done` outside WAIT_ECC is ignored, including in the START cycle.
  - A request dropped before its grant is never serviced.
- Reset, including mid-packet: state→IDLE, `last`=video, counter=0, idx=0, pending bytes discarded. All outputs go to 0, `ecc_hdr` included.

## Timing
- Request seen at edge k (state IDLE) → `gnt` and `ecc_start` high in cycle k+1.
- `ecc_done` high in cycle n → `byte_valid` high from cycle n+1.
- With `byte_ready` tied high: 4 bytes in cycles n+1..n+4, `*_done` in n+5, IDLE in n+6.
- Minimum one IDLE cycle between packets; the next grant can appear at n+7 at the earliest.
- Timeout: `ecc_done` absent during TIMEOUT_CYCLES WAIT_ECC cycles → `ecc_timeout` pulse in the following cycle, IDLE the cycle after.
- All outputs registered; no combinational path from `byte_ready` to `byte_data`.

## Test plan
- Reset for 3 cycles → all outputs 0, `busy`=0; stimulus: cmd_req with hdr 24'h00_04_39, `ecc_done` pulsed 2 cycles after `ecc_start` with `ecc_in`=8'hBA → bytes 39,04,00,BA, `byte_last` only on BA, one `cmd_done`.
- Tie with both req held continuously (cmd hdr 24'h000105, vid hdr 24'h07803E) → grants alternate cmd, vid, cmd, vid; each grantee's header emitted intact.
- Backpressure: `byte_ready` low 3 cycles at idx1 → `byte_data`=8'h04 held stable, no byte skipped or repeated, `cmd_done` delayed by 3 cycles.
- Timeout with TIMEOUT_CYCLES=16 and `ecc_done` never asserted → single `ecc_timeout` pulse, no `byte_valid`, no `*_done`, next request serviced normally.
- Reset asserted during SEND at idx2 → next cycle all outputs 0, state IDLE; a subsequent tie grants cmd first.
- Stray `ecc_done` pulse in IDLE and in the START cycle → ignored; the module still waits for a `ecc_done` during WAIT_ECC and sends that cycle's `ecc_in`.
